bsg_sync_debounce: RTL



---
 rtl/bsg_sync_debounce_bit.sv | 58 +++++
 rtl/bsg_sync_debounce.sv | 44 ++++
 2 files changed

// File: rtl/bsg_sync_debounce_bit.sv
// One input bit: synchroniser chain, stability counter, registered level and edge pulses.
// Latency num_sync_p+stable_cycles_p edges from capture to data_o; free-running, no backpressure.
module bsg_sync_debounce_bit #(
  parameter int   num_sync_p      = 2,
  parameter int   stable_cycles_p = 4,
  parameter logic reset_val_p     = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic adopt_o
);

  localparam int cnt_w_lp = (stable_cycles_p > 1) ? $clog2(stable_cycles_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_term_lp = cnt_w_lp'(stable_cycles_p - 1);

  logic [num_sync_p-1:0] sync_r;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic                  s;

  assign s       = sync_r[num_sync_p-1];
  // High in the cycle before data_o flips; the top registers it as changed_o.
  assign adopt_o = (s != data_o) && (cnt_r == cnt_term_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_r <= {num_sync_p{reset_val_p}};
    end else begin
      sync_r <= {sync_r[num_sync_p-2:0], async_i};
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r  <= '0;
      data_o <= reset_val_p;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (s == data_o) begin
        cnt_r <= '0;
      end else if (adopt_o) begin
        cnt_r  <= '0;
        data_o <= s;
        rise_o <= s;
        fall_o <= ~s;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_sync_debounce.sv
// Synchronise and debounce width_p independent async levels, with per-bit rise/fall pulses.
// Latency num_sync_p+stable_cycles_p edges from capture to data_o; free-running, no backpressure.
module bsg_sync_debounce #(
  parameter int                 width_p         = 8,
  parameter int                 num_sync_p      = 2,
  parameter int                 stable_cycles_p = 4,
  parameter logic [width_p-1:0] reset_val_p     = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] async_data_i,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] rise_o,
  output logic [width_p-1:0] fall_o,
  output logic               changed_o
);

  logic [width_p-1:0] adopt;

  for (genvar i = 0; i < width_p; i++) begin : g_bit
    bsg_sync_debounce_bit #(
      .num_sync_p      (num_sync_p),
      .stable_cycles_p (stable_cycles_p),
      .reset_val_p     (reset_val_p[i])
    ) u_bit (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (async_data_i[i]),
      .data_o  (data_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i]),
      .adopt_o (adopt[i])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      changed_o <= 1'b0;
    end else begin
      changed_o <= |adopt;
    end
  end

endmodule
